pcileech_cpl_bdf_restore: RTL and testbench

- Return-path companion to the config-request BDF router. The router rewrites the function number of inbound config requests; this block undoes that rewrite on the completions that come back.
- It holds a tag-indexed table of outstanding routed config requests. On each Cpl/CplD it restores the original function number in the Completer ID, so the host sees completions from the function it addressed.
- Sits on the outbound TLP stream between the config-space responder and the PCIe TX path. It is a one-stage registered slice with full backpressure.

---
 rtl/pcileech_cpl_bdf_restore_pkg.sv | 21 ++
 rtl/pcileech_cpl_bdf_restore_if.sv | 12 +
 rtl/pcileech_cpl_bdf_restore_tag_table.sv | 88 ++++++++
 rtl/pcileech_cpl_bdf_restore.sv | 105 ++++++++++
 tb/tb_pcileech_cpl_bdf_restore.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pcileech_cpl_bdf_restore_pkg.sv
// pcileech_cpl_pkg: completion header constants, tag-table entry type and counter helper
package pcileech_cpl_pkg;
    localparam logic [6:0] FMT_CPL      = 7'h0A;
    localparam logic [6:0] FMT_CPLD     = 7'h4A;
    localparam int         HDR_FMT_LO   = 24;
    localparam int         HDR_FUNC_LO  = 48;
    localparam int         HDR_TAG_LO   = 72;
    localparam int         CPL_TS_WIDTH = 16;

    typedef struct packed {
        logic                    valid;
        logic [7:0]              tag;
        logic [2:0]              orig_func;
        logic [2:0]              routed_func;
        logic [CPL_TS_WIDTH-1:0] ts;
    } cpl_tag_entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return v + 16'(en && v != 16'hFFFF);
    endfunction
endpackage

// File: rtl/pcileech_cpl_bdf_restore_if.sv
// IfAXIS128: 128-bit AXI-Stream TLP bus; tuser[0] marks the first beat of a TLP
interface IfAXIS128;
    logic [127:0] tdata;
    logic [15:0]  tkeep;
    logic         tlast;
    logic [31:0]  tuser;
    logic         tvalid;
    logic         tready;

    modport source(output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport sink(input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pcileech_cpl_bdf_restore_tag_table.sv
// pcileech_cpl_tag_table: outstanding routed-request table with insert/release/sweep arbitration
// Expiry and collision counters exist only when PCILEECH_CPL_RESTORE_STATS_EN is defined.
module pcileech_cpl_tag_table
    import pcileech_cpl_pkg::*;
#(
    parameter int                  TAG_BITS       = 5,
    parameter int                  TS_WIDTH       = 16,
    parameter logic [TS_WIDTH-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ins_valid_i,
    input  logic [7:0]          ins_tag_i,
    input  logic [2:0]          ins_orig_func_i,
    input  logic [2:0]          ins_routed_func_i,
    input  logic                lk_valid_i,
    input  logic [7:0]          lk_tag_i,
    input  logic [2:0]          lk_func_i,
    output logic                lk_hit_o,
    output logic [2:0]          lk_orig_func_o,
    output logic [TAG_BITS:0]   outstanding_count_o,
    output logic [15:0]         timeout_count_o,
    output logic [15:0]         collision_count_o
);
    localparam int DEPTH = 1 << TAG_BITS;

    cpl_tag_entry_t      tbl_q [DEPTH];
    logic [TAG_BITS-1:0] ins_idx, lk_idx, sweep_q;
    logic [TS_WIDTH-1:0] ts_q, age;
    logic                release_en, expire_en;
    logic [TAG_BITS:0]   pop_d, count_q;

    // lookup sees pre-update contents; insert beats release beats sweep on a shared index
    always_comb begin
        ins_idx        = ins_tag_i[TAG_BITS-1:0];
        lk_idx         = lk_tag_i[TAG_BITS-1:0];
        lk_hit_o       = lk_valid_i && tbl_q[lk_idx].valid && tbl_q[lk_idx].tag == lk_tag_i &&
                         tbl_q[lk_idx].routed_func == lk_func_i;
        lk_orig_func_o = tbl_q[lk_idx].orig_func;
        release_en     = lk_hit_o && !(ins_valid_i && ins_idx == lk_idx);
        age            = ts_q - TS_WIDTH'(tbl_q[sweep_q].ts);
        expire_en      = tbl_q[sweep_q].valid && age >= TIMEOUT_CYCLES &&
                         !(ins_valid_i && ins_idx == sweep_q) && !(lk_hit_o && lk_idx == sweep_q);
        pop_d          = '0;
        for (int i = 0; i < DEPTH; i++) pop_d = pop_d + (TAG_BITS+1)'(tbl_q[i].valid);
    end

    // table state, free-running timestamp, sweep pointer and registered popcount
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            sweep_q <= '0;
            ts_q    <= '0;
            count_q <= '0;
        end else begin
            ts_q    <= ts_q + 1'b1;
            sweep_q <= sweep_q + 1'b1;
            count_q <= pop_d;
            if (expire_en) tbl_q[sweep_q].valid <= 1'b0;
            if (release_en) tbl_q[lk_idx].valid <= 1'b0;
            if (ins_valid_i) tbl_q[ins_idx] <= '{1'b1, ins_tag_i, ins_orig_func_i, ins_routed_func_i,
                                                 CPL_TS_WIDTH'(ts_q)};
        end
    end

    assign outstanding_count_o = count_q;

`ifdef PCILEECH_CPL_RESTORE_STATS_EN
    logic [15:0] timeout_q, collision_q;

    // saturating counts of sweeper expiries and inserts over a live entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_q   <= '0;
            collision_q <= '0;
        end else begin
            timeout_q   <= sat_inc(timeout_q, expire_en);
            collision_q <= sat_inc(collision_q, ins_valid_i && tbl_q[ins_idx].valid);
        end
    end

    assign timeout_count_o   = timeout_q;
    assign collision_count_o = collision_q;
`else
    assign timeout_count_o   = '0;
    assign collision_count_o = '0;
`endif
endmodule

// File: rtl/pcileech_cpl_bdf_restore.sv
// pcileech_cpl_bdf_restore: registered AXIS slice restoring the original function in completion IDs
// Statistics counters are built only when PCILEECH_CPL_RESTORE_STATS_EN is defined.
module pcileech_cpl_bdf_restore
    import pcileech_cpl_pkg::*;
#(
    parameter int                  TAG_BITS       = 5,
    parameter int                  TS_WIDTH       = 16,
    parameter logic [TS_WIDTH-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic              clk_pcie,
    input  logic              rst_n,
    input  logic              restore_enabled,
    input  logic              req_valid,
    input  logic [7:0]        req_tag,
    input  logic [2:0]        req_orig_func,
    input  logic [2:0]        req_routed_func,
    IfAXIS128.sink            tlps_in,
    IfAXIS128.source          tlps_out,
    output logic [TAG_BITS:0] outstanding_count,
    output logic [15:0]       miss_count,
    output logic [15:0]       timeout_count,
    output logic [15:0]       collision_count
);
    logic         out_valid_q, tlast_q;
    logic [127:0] tdata_q, tdata_d;
    logic [15:0]  tkeep_q;
    logic [31:0]  tuser_q;
    logic         accept, is_cpl, lk_valid, lk_hit;
    logic [2:0]   lk_orig_func, cpl_func;
    logic [6:0]   fmt_type;
    logic [7:0]   cpl_tag;

    assign tlps_in.tready  = !out_valid_q || tlps_out.tready;
    assign tlps_out.tvalid = out_valid_q;
    assign tlps_out.tdata  = tdata_q;
    assign tlps_out.tkeep  = tkeep_q;
    assign tlps_out.tlast  = tlast_q;
    assign tlps_out.tuser  = tuser_q;

    // decode first-beat completion headers and splice the original function back on a hit
    always_comb begin
        fmt_type = tlps_in.tdata[HDR_FMT_LO +: 7];
        cpl_func = tlps_in.tdata[HDR_FUNC_LO +: 3];
        cpl_tag  = tlps_in.tdata[HDR_TAG_LO +: 8];
        accept   = tlps_in.tvalid && tlps_in.tready;
        is_cpl   = fmt_type == FMT_CPL || fmt_type == FMT_CPLD;
        lk_valid = accept && tlps_in.tuser[0] && is_cpl;
        tdata_d  = tlps_in.tdata;
        tdata_d[HDR_FUNC_LO +: 3] = (lk_hit && restore_enabled) ? lk_orig_func : cpl_func;
    end

    // output register: fields load only on accept so they hold steady under backpressure
    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            tdata_q     <= tdata_d;
            tkeep_q     <= tlps_in.tkeep;
            tlast_q     <= tlps_in.tlast;
            tuser_q     <= tlps_in.tuser;
        end else if (tlps_out.tready) begin
            out_valid_q <= 1'b0;
        end
    end

    pcileech_cpl_tag_table #(
        .TAG_BITS       (TAG_BITS),
        .TS_WIDTH       (TS_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_table (
        .clk_i               (clk_pcie),
        .rst_ni              (rst_n),
        .ins_valid_i         (req_valid),
        .ins_tag_i           (req_tag),
        .ins_orig_func_i     (req_orig_func),
        .ins_routed_func_i   (req_routed_func),
        .lk_valid_i          (lk_valid),
        .lk_tag_i            (cpl_tag),
        .lk_func_i           (cpl_func),
        .lk_hit_o            (lk_hit),
        .lk_orig_func_o      (lk_orig_func),
        .outstanding_count_o (outstanding_count),
        .timeout_count_o     (timeout_count),
        .collision_count_o   (collision_count)
    );

`ifdef PCILEECH_CPL_RESTORE_STATS_EN
    logic [15:0] miss_q;

    // saturating count of completions that found no matching entry
    always_ff @(posedge clk_pcie or negedge rst_n) begin
        if (!rst_n) miss_q <= '0;
        else miss_q <= sat_inc(miss_q, lk_valid && !lk_hit);
    end

    assign miss_count = miss_q;
`else
    assign miss_count = '0;
`endif
endmodule

// File: tb/tb_pcileech_cpl_bdf_restore.sv
// tb_pcileech_cpl_bdf_restore: directed self-checking bench for the completion BDF restore slice
module tb_pcileech_cpl_bdf_restore;
    localparam logic [6:0] CPL  = 7'h0A;
    localparam logic [6:0] CPLD = 7'h4A;
    localparam logic [6:0] MRD  = 7'h00;
`ifdef PCILEECH_CPL_RESTORE_STATS_EN
    localparam bit ST = 1'b1;
`else
    localparam bit ST = 1'b0;
`endif

    logic       clk_pcie = 1'b0;
    logic       rst_n = 1'b0;
    logic       restore_enabled = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_tag = '0;
    logic [2:0] req_orig_func = '0, req_routed_func = '0;
    logic [5:0] outstanding_count;
    logic [15:0] miss_count, timeout_count, collision_count;
    int checks = 0, errors = 0;

    IfAXIS128 in_if();
    IfAXIS128 out_if();

    pcileech_cpl_bdf_restore #(.TAG_BITS(5), .TS_WIDTH(16), .TIMEOUT_CYCLES(16'd100)) dut (
        .clk_pcie          (clk_pcie),
        .rst_n             (rst_n),
        .restore_enabled   (restore_enabled),
        .req_valid         (req_valid),
        .req_tag           (req_tag),
        .req_orig_func     (req_orig_func),
        .req_routed_func   (req_routed_func),
        .tlps_in           (in_if),
        .tlps_out          (out_if),
        .outstanding_count (outstanding_count),
        .miss_count        (miss_count),
        .timeout_count     (timeout_count),
        .collision_count   (collision_count)
    );

    always #5 clk_pcie = ~clk_pcie;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] hdr(input logic [6:0] fmt, input logic [2:0] fn, input logic [7:0] tag);
        logic [127:0] d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d[30:24] = fmt;
        d[50:48] = fn;
        d[79:72] = tag;
        return d;
    endfunction

    task automatic step();
        @(posedge clk_pcie);
        #1;
    endtask

    task automatic ins(input logic [7:0] tag, input logic [2:0] orig, input logic [2:0] routed);
        req_valid = 1'b1;
        req_tag = tag;
        req_orig_func = orig;
        req_routed_func = routed;
        step();
        req_valid = 1'b0;
    endtask

    task automatic drive(input logic [127:0] d, input logic first);
        in_if.tvalid = 1'b1;
        in_if.tdata = d;
        in_if.tkeep = 16'hFFFF;
        in_if.tlast = 1'b1;
        in_if.tuser = {31'h0, first};
    endtask

    task automatic xfer(input logic [127:0] d, input logic first);
        drive(d, first);
        step();
        in_if.tvalid = 1'b0;
    endtask

    initial begin
        int n;
        in_if.tvalid = 1'b0;
        in_if.tdata = '0;
        in_if.tkeep = '0;
        in_if.tlast = 1'b0;
        in_if.tuser = '0;
        out_if.tready = 1'b1;
        #1;
        chk("rst_tvalid", out_if.tvalid, 0);
        chk("rst_count", outstanding_count, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        ins(8'h05, 3'd2, 3'd0);
        step();
        chk("t1_count1", outstanding_count, 1);
        xfer(hdr(CPLD, 3'd0, 8'h05), 1'b1);
        chk("t1_valid", out_if.tvalid, 1);
        chk("t1_data", out_if.tdata, hdr(CPLD, 3'd2, 8'h05));
        chk("t1_keep", out_if.tkeep, 16'hFFFF);
        step();
        chk("t1_count0", outstanding_count, 0);

        xfer(hdr(CPLD, 3'd0, 8'h07), 1'b1);
        chk("t2_data", out_if.tdata, hdr(CPLD, 3'd0, 8'h07));
        chk("t2_miss", miss_count, ST ? 16'd1 : 16'd0);

        ins(8'h03, 3'd1, 3'd3);
        out_if.tready = 1'b0;
        drive(hdr(CPL, 3'd3, 8'h03), 1'b1);
        step();
        drive(hdr(MRD, 3'd3, 8'h03), 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_in_ready", in_if.tready, 0);
            chk("t3_out_valid", out_if.tvalid, 1);
            chk("t3_hold", out_if.tdata, hdr(CPL, 3'd1, 8'h03));
            step();
        end
        out_if.tready = 1'b1;
        #1;
        chk("t3_in_ready1", in_if.tready, 1);
        step();
        in_if.tvalid = 1'b0;
        chk("t3_next", out_if.tdata, hdr(MRD, 3'd3, 8'h03));
        step();
        chk("t3_drain", out_if.tvalid, 0);
        chk("t3_count", outstanding_count, 0);
        chk("t3_miss", miss_count, ST ? 16'd1 : 16'd0);

        ins(8'h09, 3'd4, 3'd1);
        step();
        chk("t4_count1", outstanding_count, 1);
        n = 0;
        while (outstanding_count != 0 && n < 200) begin
            step();
            n++;
        end
        chk("t4_window", n >= 100 && n <= 132, 1);
        chk("t4_timeout", timeout_count, ST ? 16'd1 : 16'd0);
        xfer(hdr(CPLD, 3'd1, 8'h09), 1'b1);
        chk("t4_data", out_if.tdata, hdr(CPLD, 3'd1, 8'h09));
        chk("t4_miss", miss_count, ST ? 16'd2 : 16'd0);

        ins(8'h04, 3'd1, 3'd2);
        ins(8'h24, 3'd3, 3'd2);
        chk("t5_coll", collision_count, ST ? 16'd1 : 16'd0);
        xfer(hdr(CPLD, 3'd2, 8'h04), 1'b1);
        chk("t5_miss_data", out_if.tdata, hdr(CPLD, 3'd2, 8'h04));
        chk("t5_miss", miss_count, ST ? 16'd3 : 16'd0);
        xfer(hdr(CPLD, 3'd2, 8'h24), 1'b1);
        chk("t5_hit_data", out_if.tdata, hdr(CPLD, 3'd3, 8'h24));
        step();
        chk("t5_count", outstanding_count, 0);

        ins(8'h10, 3'd5, 3'd1);
        restore_enabled = 1'b0;
        xfer(hdr(CPLD, 3'd1, 8'h10), 1'b1);
        chk("t6_passthru", out_if.tdata, hdr(CPLD, 3'd1, 8'h10));
        step();
        chk("t6_released", outstanding_count, 0);
        chk("t6_miss", miss_count, ST ? 16'd3 : 16'd0);
        restore_enabled = 1'b1;

        ins(8'h12, 3'd3, 3'd0);
        xfer(hdr(CPL, 3'd0, 8'h12), 1'b0);
        chk("t7_nonfirst", out_if.tdata, hdr(CPL, 3'd0, 8'h12));
        chk("t7_kept", outstanding_count, 1);
        xfer(hdr(CPL, 3'd0, 8'h12), 1'b1);
        chk("t7_first", out_if.tdata, hdr(CPL, 3'd3, 8'h12));
        step();
        chk("t7_count", outstanding_count, 0);

        ins(8'h11, 3'd6, 3'd2);
        req_valid = 1'b1;
        req_tag = 8'h11;
        req_orig_func = 3'd7;
        req_routed_func = 3'd2;
        xfer(hdr(CPL, 3'd2, 8'h11), 1'b1);
        req_valid = 1'b0;
        chk("t8_old_entry", out_if.tdata, hdr(CPL, 3'd6, 8'h11));
        chk("t8_coll", collision_count, ST ? 16'd2 : 16'd0);
        step();
        chk("t8_kept", outstanding_count, 1);
        xfer(hdr(CPL, 3'd2, 8'h11), 1'b1);
        chk("t8_new_entry", out_if.tdata, hdr(CPL, 3'd7, 8'h11));
        step();
        chk("t8_count", outstanding_count, 0);

        ins(8'h01, 3'd4, 3'd1);
        ins(8'h02, 3'd5, 3'd1);
        ins(8'h03, 3'd6, 3'd1);
        step();
        chk("t9_count3", outstanding_count, 3);
        out_if.tready = 1'b0;
        xfer(hdr(MRD, 3'd0, 8'h00), 1'b1);
        chk("t9_inflight", out_if.tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t9_rst_valid", out_if.tvalid, 0);
        chk("t9_rst_count", outstanding_count, 0);
        chk("t9_rst_miss", miss_count, 0);
        step(); step();
        rst_n = 1'b1;
        out_if.tready = 1'b1;
        step();
        xfer(hdr(CPLD, 3'd1, 8'h01), 1'b1);
        chk("t9_after_data", out_if.tdata, hdr(CPLD, 3'd1, 8'h01));
        chk("t9_after_miss", miss_count, ST ? 16'd1 : 16'd0);
        chk("t9_after_coll", collision_count, 0);
        step();
        chk("t9_after_count", outstanding_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
